// File: rtl/addsub_seq_if.sv
// addsub_seq_if: request/result bundle for the multi-cycle adder/subtractor.
//   master: drives start, A, B, Cin, Control; observes busy, done, S, Cout, O, Z
//   slave : the arithmetic unit (mirror directions)
// WIDTH must match the WIDTH of the addsub_seq instance it is connected to.
interface addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             O;
  logic             Z;

  modport master (
    output start, A, B, Cin, Control,
    input  busy, done, S, Cout, O, Z
  );

  modport slave (
    input  start, A, B, Cin, Control,
    output busy, done, S, Cout, O, Z
  );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any operation in flight
//   bus   : addsub_seq_if.slave
//     start/A/B/Cin/Control : request, sampled while busy=0
//     busy                  : operation in progress
//     done                  : one-cycle pulse when S/Cout/O/Z update
//     S, Cout, O, Z         : registered result and flags, held between ops
// Subtraction is A + ~B + (Cin ^ Control), so with Control=1 Cin acts as a
// borrow-in and Cout=1 means "no borrow".

// CHUNK-bit carry-lookahead stage. Every carry is expanded as a flat
// generate/propagate sum-of-products from cin, so no carry depends on
// another carry.
module addsub_seq_cla #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb   // carry into bit N-1, for signed overflow
);
  logic [N-1:0] p, g;
  logic [N:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic acc_p;
    logic cc;
    acc_p = 1'b1;
    cc    = 1'b0;
    c     = '0;
    c[0]  = cin;
    for (int i = 0; i < N; i++) begin
      cc    = 1'b0;
      acc_p = 1'b1;
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
      for (int j = i; j >= 0; j--) begin
        cc    = cc | (acc_p & g[j]);
        acc_p = acc_p & p[j];
      end
      c[i+1] = cc | (acc_p & cin);
    end
  end

  assign sum   = p ^ c[N-1:0];
  assign cout  = c[N];
  assign c_msb = c[N-1];
endmodule

module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         reset,
  addsub_seq_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [NCH-1:0][CHUNK-1:0] a_q, bx_q, res_q, res_nxt;
  logic                      carry_q;
  logic [CW-1:0]             cnt_q;
  logic                      done_q, cout_q, o_q, z_q;
  logic [WIDTH-1:0]          s_q;

  logic [CHUNK-1:0] a_k, b_k, sum_k;
  logic             cout_k, cmsb_k;
  logic             accept, last;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (cnt_q == CW'(NCH - 1));

  // Select the active chunk of both operands.
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) begin
        a_k = a_q[i];
        b_k = bx_q[i];
      end
    end
  end

  addsub_seq_cla #(.N(CHUNK)) u_cla (
    .a     (a_k),
    .b     (b_k),
    .cin   (carry_q),
    .sum   (sum_k),
    .cout  (cout_k),
    .c_msb (cmsb_k)
  );

  // Partial result with the current chunk merged in; on the last chunk this
  // is the complete result, which goes straight to S.
  always_comb begin
    res_nxt = res_q;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) res_nxt[i] = sum_k;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      bx_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      o_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= bus.A;
        bx_q    <= bus.B ^ {WIDTH{bus.Control}};
        carry_q <= bus.Cin ^ bus.Control;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        res_q   <= res_nxt;
        carry_q <= cout_k;
        cnt_q   <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          s_q    <= res_nxt;
          cout_q <= cout_k;
          o_q    <= cout_k ^ cmsb_k;
          z_q    <= (res_nxt == '0);
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.O    = o_q;
  assign bus.Z    = z_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed and random ops on WIDTH=32/CHUNK=8, plus
// random sweeps on CHUNK=32 and WIDTH=16/CHUNK=4, all against a behavioural
// scoreboard.
module tb_addsub_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(32)) b0 ();
  addsub_seq_if #(.WIDTH(32)) b1 ();
  addsub_seq_if #(.WIDTH(16)) b2 ();

  addsub_seq #(.WIDTH(32), .CHUNK(8))  u0 (.clk(clk), .reset(reset), .bus(b0));
  addsub_seq #(.WIDTH(32), .CHUNK(32)) u1 (.clk(clk), .reset(reset), .bus(b1));
  addsub_seq #(.WIDTH(16), .CHUNK(4))  u2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic [31:0] s;
    logic        cout, o, z;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, ctl;
    logic [31:0] s;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // w-bit reference: A + (B ^ Control) + (Cin ^ Control); signed overflow
  // from operand/result sign bits.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic cin, logic ctl);
    logic [32:0] mask, aa, bb, r;
    exp_t e;
    mask   = (33'd1 << w) - 33'd1;
    aa     = {1'b0, a} & mask;
    bb     = {1'b0, (ctl ? ~b : b)} & mask;
    r      = aa + bb + {32'd0, cin ^ ctl};
    e.s    = r[31:0] & mask[31:0];
    e.cout = r[w];
    e.o    = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    e.z    = (e.s == 32'd0);
    return e;
  endfunction

  // Call at a negedge with busy=0; returns at the negedge after acceptance.
  task automatic issue0(logic [31:0] a, logic [31:0] b, logic cin, logic ctl);
    b0.A = a; b0.B = b; b0.Cin = cin; b0.Control = ctl; b0.start = 1'b1;
    q0.push_back(model(32, a, b, cin, ctl));
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  // Bounded wait for done on u0; lat counts edges after acceptance.
  task automatic wait_done0(output int lat, output int busy_cyc, output bit seen);
    lat = 0; busy_cyc = 0; seen = 1'b0;
    while (lat < 20) begin
      if (b0.done) begin seen = 1'b1; break; end
      if (b0.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b0.start = 0; b1.start = 0; b2.start = 0;
    b0.A = 0; b0.B = 0; b0.Cin = 0; b0.Control = 0;
    b1.A = 0; b1.B = 0; b1.Cin = 0; b1.Control = 0;
    b2.A = 0; b2.B = 0; b2.Cin = 0; b2.Control = 0;
    @(negedge clk);
    n_cmp++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
    n_cmp++; if (b0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", b0.done); end
    n_cmp++; if ({b0.S, b0.Cout, b0.O, b0.Z} !== 35'd0) begin n_fail++;
      $display("FAIL reset_outs: got S=%h C=%b O=%b Z=%b want all 0", b0.S, b0.Cout, b0.O, b0.Z); end
    n_cmp++; if ({b1.busy, b2.busy, b2.S} !== 18'd0) begin n_fail++;
      $display("FAIL reset_sweep: got busy1=%b busy2=%b S2=%h want 0", b1.busy, b2.busy, b2.S); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", b0.busy); end
  endtask

  task automatic test_basic();
    int lat, bc; bit seen; exp_t e;
    issue0(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done0(lat, bc, seen);
    n_cmp++; if (!seen || lat != 4) begin n_fail++; $display("FAIL basic_latency: got %0d (seen=%b) want 4", lat, seen); end
    n_cmp++; if (bc != 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    n_cmp++; if ({b0.S, b0.Cout, b0.O, b0.Z} !== {32'h80000000, 1'b0, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL basic_result: got S=%h C=%b O=%b Z=%b want S=80000000 C=0 O=1 Z=0", b0.S, b0.Cout, b0.O, b0.Z); end
    e = q0.pop_front();
    @(negedge clk);
    n_cmp++; if (b0.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", b0.done); end
  endtask

  // Directed table: literal S plus full model comparison for flags.
  task automatic test_arith();
    vec_t v[5];
    int lat, bc; bit seen; exp_t e;
    v[0] = '{32'd5,        32'd5, 1'b0, 1'b1, 32'h00000000};
    v[1] = '{32'd0,        32'd1, 1'b0, 1'b1, 32'hFFFFFFFF};
    v[2] = '{32'h00FFFFFF, 32'd1, 1'b0, 1'b0, 32'h01000000};
    v[3] = '{32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'h00000000};
    v[4] = '{32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF};
    foreach (v[i]) begin
      issue0(v[i].a, v[i].b, v[i].cin, v[i].ctl);
      wait_done0(lat, bc, seen);
      e = q0.pop_front();
      n_cmp++; if (!seen || b0.S !== v[i].s) begin n_fail++;
        $display("FAIL arith_S[%0d]: got %h (seen=%b) want %h", i, b0.S, seen, v[i].s); end
      n_cmp++; if ({b0.S, b0.Cout, b0.O, b0.Z} !== {e.s, e.cout, e.o, e.z}) begin n_fail++;
        $display("FAIL arith_flags[%0d]: got C=%b O=%b Z=%b want C=%b O=%b Z=%b", i, b0.Cout, b0.O, b0.Z, e.cout, e.o, e.z); end
    end
  endtask

  task automatic test_ignore_busy();
    int lat, bc, extra; bit seen; exp_t e;
    issue0(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    b0.A = 32'hDEADBEEF; b0.B = 32'h0BADF00D; b0.Control = 1'b1; b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    wait_done0(lat, bc, seen);
    e = q0.pop_front();
    n_cmp++; if (!seen || {b0.S, b0.Cout, b0.O, b0.Z} !== {e.s, e.cout, e.o, e.z}) begin n_fail++;
      $display("FAIL ignore_result: got S=%h (seen=%b) want %h", b0.S, seen, e.s); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (b0.done) extra++; end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, unstable; bit seen; exp_t e1, e2;
    issue0(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 1'b0);
    wait_done0(lat, bc, seen);
    e1 = q0.pop_front();
    n_cmp++; if (!seen || b0.S !== e1.s) begin n_fail++; $display("FAIL b2b_first: got %h want %h", b0.S, e1.s); end
    issue0(32'h00001000, 32'h00002000, 1'b1, 1'b1);   // accepted in the done cycle
    n_cmp++; if (b0.busy !== 1'b1 || b0.done !== 1'b0) begin n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", b0.busy, b0.done); end
    lat = 0; unstable = 0; seen = 1'b0;
    while (lat < 20) begin
      if (b0.done) begin seen = 1'b1; break; end
      if (b0.S !== e1.s) unstable++;
      @(negedge clk); lat++;
    end
    n_cmp++; if (unstable != 0) begin n_fail++; $display("FAIL b2b_S_stable: got %0d changed cycles want 0", unstable); end
    n_cmp++; if (!seen || lat != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    e2 = q0.pop_front();
    n_cmp++; if ({b0.S, b0.Cout, b0.O, b0.Z} !== {e2.s, e2.cout, e2.o, e2.z}) begin n_fail++;
      $display("FAIL b2b_second: got S=%h C=%b O=%b Z=%b want S=%h C=%b O=%b Z=%b",
               b0.S, b0.Cout, b0.O, b0.Z, e2.s, e2.cout, e2.o, e2.z); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones; bit seen; exp_t e;
    issue0(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(negedge clk);              // second RUN cycle
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_ctrl: got busy=%b done=%b want 0 0", b0.busy, b0.done); end
    n_cmp++; if ({b0.S, b0.Cout, b0.O, b0.Z} !== 35'd0) begin n_fail++;
      $display("FAIL rstmid_outs: got S=%h C=%b O=%b Z=%b want all 0", b0.S, b0.Cout, b0.O, b0.Z); end
    q0.delete();
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (b0.done || b0.busy) dones++; end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", dones); end
    issue0(32'hCAFEF00D, 32'h01234567, 1'b1, 1'b1);
    wait_done0(lat, bc, seen);
    e = q0.pop_front();
    n_cmp++; if (!seen || {b0.S, b0.Cout, b0.O, b0.Z} !== {e.s, e.cout, e.o, e.z}) begin n_fail++;
      $display("FAIL rstmid_fresh: got S=%h (seen=%b) want %h", b0.S, seen, e.s); end
  endtask

  task automatic test_random_main();
    int lat, bc, bad; bit seen; exp_t e;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      issue0($urandom, $urandom, 1'($urandom), 1'($urandom));
      wait_done0(lat, bc, seen);
      e = q0.pop_front();
      n_cmp++; if (!seen || lat != 4 || {b0.S, b0.Cout, b0.O, b0.Z} !== {e.s, e.cout, e.o, e.z}) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand32x8[%0d]: got S=%h C=%b O=%b Z=%b lat=%0d want S=%h C=%b O=%b Z=%b lat=4",
                               i, b0.S, b0.Cout, b0.O, b0.Z, lat, e.s, e.cout, e.o, e.z);
      end
    end
  endtask

  task automatic test_param_sweep();
    fork
      begin : sweep_c32
        int left, idle, bad; logic [31:0] a, b; logic ci, ct; exp_t e;
        left = 10000; idle = 0; bad = 0;
        while ((left > 0 || q1.size() > 0) && idle < 20) begin
          @(negedge clk);
          if (b1.done) begin
            idle = 0;
            n_cmp++;
            if (q1.size() == 0) begin n_fail++; $display("FAIL c32_spurious_done: got done want none"); end
            else begin
              e = q1.pop_front();
              if ({b1.S, b1.Cout, b1.O, b1.Z} !== {e.s, e.cout, e.o, e.z}) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL c32_result: got S=%h C=%b O=%b Z=%b want S=%h C=%b O=%b Z=%b",
                                       b1.S, b1.Cout, b1.O, b1.Z, e.s, e.cout, e.o, e.z);
              end
            end
          end else idle++;
          if (!b1.busy && left > 0) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); ct = 1'($urandom);
            b1.A = a; b1.B = b; b1.Cin = ci; b1.Control = ct; b1.start = 1'b1;
            q1.push_back(model(32, a, b, ci, ct));
            left--;
          end else b1.start = 1'b0;
        end
        b1.start = 1'b0;
        n_cmp++; if (idle >= 20) begin n_fail++; $display("FAIL c32_timeout: got %0d pending want 0", q1.size()); end
      end
      begin : sweep_w16
        int left, idle, bad; logic [31:0] a, b; logic ci, ct; exp_t e;
        left = 5000; idle = 0; bad = 0;
        while ((left > 0 || q2.size() > 0) && idle < 20) begin
          @(negedge clk);
          if (b2.done) begin
            idle = 0;
            n_cmp++;
            if (q2.size() == 0) begin n_fail++; $display("FAIL w16_spurious_done: got done want none"); end
            else begin
              e = q2.pop_front();
              if ({b2.S, b2.Cout, b2.O, b2.Z} !== {e.s[15:0], e.cout, e.o, e.z}) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL w16_result: got S=%h C=%b O=%b Z=%b want S=%h C=%b O=%b Z=%b",
                                       b2.S, b2.Cout, b2.O, b2.Z, e.s[15:0], e.cout, e.o, e.z);
              end
            end
          end else idle++;
          if (!b2.busy && left > 0) begin
            a = $urandom & 32'hFFFF; b = $urandom & 32'hFFFF; ci = 1'($urandom); ct = 1'($urandom);
            b2.A = a[15:0]; b2.B = b[15:0]; b2.Cin = ci; b2.Control = ct; b2.start = 1'b1;
            q2.push_back(model(16, a, b, ci, ct));
            left--;
          end else b2.start = 1'b0;
        end
        b2.start = 1'b0;
        n_cmp++; if (idle >= 20) begin n_fail++; $display("FAIL w16_timeout: got %0d pending want 0", q2.size()); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random_main();
    test_param_sweep();
    n_cmp++; if (q0.size() != 0) begin n_fail++; $display("FAIL q0_drain: got %0d left want 0", q0.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
